// File: rtl/cdc_pkg.sv
// Shared types, widths and the bubble-correction helper
// for the capacitance-to-digital front-end capture stage.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACQUIRE,
    DONE
  } state_e;

  localparam int THERM_WIDTH = 8;

  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int STABLE_COUNT_DEF  = 3;
  localparam int ACQ_TIMEOUT_DEF   = 32;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int SETTLE_W = cnt_w(SETTLE_CYCLES_DEF);
  localparam int MATCH_W  = cnt_w(STABLE_COUNT_DEF);
  localparam int ACQ_W    = cnt_w(ACQ_TIMEOUT_DEF);

  // 3-input majority per bit; above the top is 0, below bit 0 is 1
  function automatic logic [THERM_WIDTH-1:0] bubble_fix(
    input logic [THERM_WIDTH-1:0] s
  );
    logic [THERM_WIDTH+1:0] e;
    logic [THERM_WIDTH-1:0] r;
    e = {1'b0, s, 1'b1};
    r = '0;
    for (int i = 0; i < THERM_WIDTH; i++) begin
      r[i] = (e[i+2] & e[i+1]) |
             (e[i+1] & e[i])   |
             (e[i+2] & e[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_sync_ff.sv
// Multi-bit synchroniser chain, STAGES flops deep,
// asynchronous active-low reset to zero.
module cdc_sync_ff #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_thermo_sampler.sv
// Comparator-ladder sampler: synchronise, settle, acquire
// until stable (or timeout), then hold a corrected word.
module cdc_thermo_sampler
  import cdc_pkg::*;
#(
  parameter int WIDTH         = THERM_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int STABLE_COUNT  = STABLE_COUNT_DEF,
  parameter int ACQ_TIMEOUT   = ACQ_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] comp_in,
  output logic [WIDTH-1:0] therm_out,
  output logic             valid,
  output logic             busy,
  output logic             unstable,
  output logic             below_range
);

  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int MW = cnt_w(STABLE_COUNT);
  localparam int AW = cnt_w(ACQ_TIMEOUT);

  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES);
  localparam logic [MW-1:0] STABLE_END = MW'(STABLE_COUNT);
  localparam logic [AW-1:0] ACQ_END    = AW'(ACQ_TIMEOUT);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [AW-1:0]    acq_q, acq_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] therm_q, therm_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             unst_q, unst_d;
  logic             below_q, below_d;
  logic             stable;

  cdc_sync_ff #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (comp_in),
    .q_o  (s)
  );

  assign c = bubble_fix(s);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    acq_d    = acq_q;
    match_d  = match_q;
    ref_d    = ref_q;
    therm_d  = therm_q;
    unst_d   = unst_q;
    below_d  = below_q;
    valid_d  = 1'b0;
    stable   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_d == SETTLE_END) begin
          state_d = ACQUIRE;
          acq_d   = '0;
          match_d = '0;
        end
      end
      ACQUIRE: begin
        acq_d = acq_q + 1'b1;
        if (match_q == '0 || c != ref_q) begin
          ref_d   = c;
          match_d = MW'(1);
        end else begin
          match_d = match_q + 1'b1;
        end
        // a fresh reference sets the count to 1, never STABLE_END
        stable = (match_d == STABLE_END);
        if (stable || acq_d == ACQ_END) begin
          therm_d = c;
          unst_d  = !stable;
          below_d = (c == '0);
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SETTLE) || (state_d == ACQUIRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      acq_q    <= '0;
      match_q  <= '0;
      ref_q    <= '0;
      therm_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      unst_q   <= 1'b0;
      below_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      acq_q    <= acq_d;
      match_q  <= match_d;
      ref_q    <= ref_d;
      therm_q  <= therm_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      unst_q   <= unst_d;
      below_q  <= below_d;
    end
  end

  assign therm_out   = therm_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign unstable    = unst_q;
  assign below_range = below_q;

endmodule

// File: doc/cdc_thermo_sampler.md
Name: cdc_thermo_sampler

Overview:
- Front-end capture stage of the capacitance-to-digital converter.
- Synchronises the 8 asynchronous comparator-ladder outputs into the clock domain and runs one conversion per start request: settle, then acquire until stable.
- Applies single-bubble correction and holds a registered thermometer word for the downstream 8-to-3 priority encoder.
- Flags unstable and below-range conversions.

Parameters:
- WIDTH, 8, comparator/thermometer width. Fixed at 8 to match the encoder input.
- SYNC_STAGES, 2, number of synchroniser flops per comparator bit; must be ≥2.
- SETTLE_CYCLES, 4, cycles waited after start before sampling begins; must be ≥1.
- STABLE_COUNT, 3, number of consecutive identical corrected samples required; must be ≥2.
- ACQ_TIMEOUT, 32, maximum cycles spent in ACQUIRE before a forced capture; must be > STABLE_COUNT.

Ports:
- clk  in  1  system clock. All flops on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  conversion request. One-cycle pulse or level; accepted only in IDLE.
- comp_in  in  WIDTH  raw asynchronous comparator outputs; bit0 is the lowest threshold.
- therm_out  out  WIDTH  registered, bubble-corrected thermometer word; feeds the encoder d_in.
- valid  out  1  one-cycle pulse when therm_out is updated.
- busy  out  1  high in SETTLE and ACQUIRE.
- unstable  out  1  registered with therm_out; set when the capture was forced by timeout.
- below_range  out  1  registered with therm_out; set when therm_out == 0 (the encoder output is undefined for this code).

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. Synchroniser flops, therm_out, valid, busy, unstable, below_range, and all counters and the reference register go to 0.
- Synchroniser: each comp_in bit passes through SYNC_STAGES flops; s denotes the last stage.
- Bubble correction (combinational on s), giving corrected word c:
  - c[i] = majority(s[i+1], s[i], s[i-1]).
  - Boundary values: s[WIDTH] = 0, s[-1] = 1.
  - Multi-bubble patterns are not further repaired.
- FSM states: IDLE, SETTLE, ACQUIRE, DONE.
  - IDLE: if start = 1, go to SETTLE and load settle_cnt = 0.
  - SETTLE: settle_cnt increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to ACQUIRE with acq_cnt = 0 and match_cnt = 0.
  - ACQUIRE, every cycle:
    - acq_cnt increments.
    - If match_cnt == 0 or c != ref: ref <= c, match_cnt <= 1.
    - Otherwise match_cnt increments.
    - When the increment makes match_cnt == STABLE_COUNT, capture with unstable = 0.
    - Otherwise, if acq_cnt reaches ACQ_TIMEOUT, capture the current c with unstable = 1.
    - Stability takes priority over timeout in the same cycle.
  - Capture, on the same edge: therm_out <= captured word; unstable set as above; below_range <= (captured word == 0); valid <= 1; state <= DONE.
  - DONE: lasts one cycle; valid is high during it. Then go to IDLE. start is ignored in DONE.
- Latency with stable input: valid is high exactly 1 + SETTLE_CYCLES + STABLE_COUNT cycles after the cycle in which start is sampled high. With defaults, start in cycle 0 gives valid in cycle 8. This excludes the synchroniser delay for input changes.
- busy = (state == SETTLE) or (state == ACQUIRE), registered.
- start while busy or in DONE: ignored; it is neither queued nor restarts the conversion.
- therm_out, unstable and below_range hold their values between captures.
- rst_n asserted mid-conversion aborts immediately. No valid is issued, and outputs return to their reset values.

Decomposition:
- Package cdc_pkg contains:
  - state enum (IDLE, SETTLE, ACQUIRE, DONE)
  - THERM_WIDTH = 8
  - counter widths derived via clog2 of SETTLE_CYCLES, STABLE_COUNT and ACQ_TIMEOUT
- Sub-module cdc_sync_ff: one parameterised multi-bit synchroniser chain (SYNC_STAGES deep, async active-low reset to 0). Instantiated once for comp_in.

Test Plan:
- Reset, then comp_in = 8'b00011111 held stable and start pulsed in cycle 0 → valid in cycle 8; therm_out = 8'b00011111; unstable = 0; below_range = 0; busy high in cycles 1–7.
- Bubble: comp_in = 8'b00110111 stable, start → therm_out = 8'b00111111 and unstable = 0.
- Instability: comp_in toggles between 8'b00000111 and 8'b00001111 every 2 cycles, start → valid 1 + 4 + 32 = 37 cycles after start; unstable = 1; therm_out equals the corrected sample in the final ACQUIRE cycle.
- comp_in = 8'h00 stable, start → therm_out = 8'h00, below_range = 1. Next, comp_in = 8'hFF, start → therm_out = 8'hFF, below_range = 0.
- start re-pulsed in cycles 3 and 8 of a running conversion → exactly one valid, in cycle 8; state returns to IDLE in cycle 9.
- rst_n pulled low in cycle 6 of a conversion → busy = 0 and therm_out = 0 asynchronously; no valid occurs. After release, a fresh start completes normally.
